// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared encodings and helpers for the multiply/divide unit
package mul_div_unit_pkg;

    localparam int MDU_WIDTH      = 32;
    localparam int MDU_ITERATIONS = MDU_WIDTH;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_MUL   = 2'b01,
        S_DIV   = 2'b10,
        S_FIXUP = 2'b11
    } mdu_state_e;

    // Signed variants are MULT and DIV; everything else works on raw magnitudes.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// rtl/mul_div_unit_step.sv - one combinational shift-add / restoring shift-subtract iteration
module mdu_step
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_out
);

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits being shifted out / quotient bits shifted in}.
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Compute both step flavours and pick the one for the current operation.
    always_comb begin
        sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
        shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        acc_out = '0;
        if (is_div) begin
            // Remainder stays below the divisor, so a clear top bit of diff means it fit.
            if (!diff[WIDTH]) begin
                acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             load_hi,
    input  logic             load_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mdu_state_e         state;
    mdu_state_e         next_state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand;
    logic               div_op;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               is_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic               last_iter;

    assign busy      = (state != S_IDLE);
    assign last_iter = (count == LAST_ITER);

    // Magnitudes fed to the iterator; 0x80..0 maps onto itself and is correct as unsigned.
    assign is_signed = op_is_signed(op);
    assign sign_a    = is_signed & srcA[WIDTH-1];
    assign sign_b    = is_signed & srcB[WIDTH-1];
    assign abs_a     = sign_a ? -srcA : srcA;
    assign abs_b     = sign_b ? -srcB : srcB;

    // Sign correction; divide-by-zero leaves |A| as remainder so HI recovers srcA,
    // while LO is forced to all ones regardless of signs.
    assign prod_fixed = neg_q ? -acc : acc;
    assign quo_fixed  = div_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem_fixed  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (div_op),
        .acc_in  (acc),
        .operand (operand),
        .acc_out (acc_next)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: one iteration per cycle, then a single fixup cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = op_is_div(op) ? S_DIV : S_MUL;
            S_MUL,
            S_DIV:   if (last_iter) next_state = S_FIXUP;
            S_FIXUP: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath, HI/LO and done pulse; start beats MTHI/MTLO, loads only in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            operand  <= '0;
            div_op   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count    <= '0;
                        div_op   <= op_is_div(op);
                        operand  <= op_is_div(op) ? abs_b : abs_a;
                        acc      <= {{WIDTH{1'b0}}, (op_is_div(op) ? abs_a : abs_b)};
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= op_is_div(op) && (srcB == '0);
                    end else begin
                        if (load_hi) hi <= srcA;
                        if (load_lo) lo <= srcA;
                    end
                end
                S_MUL,
                S_DIV: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                end
                S_FIXUP: begin
                    done <= 1'b1;
                    if (div_op) begin
                        hi <= rem_fixed;
                        lo <= quo_fixed;
                    end else begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
